// File: rtl/avmm_burst_mem.sv
// Avalon-MM burst agent over on-chip RAM: pipelined read bursts, write bursts, sticky protocol-error flag.
// Optional waitrequest stall injection when AVMM_BURST_MEM_STALL_EN is defined.
module avmm_burst_mem #(
  parameter int unsigned DEPTH_W      = 10,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [15:0] burstcount,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;

  state_e             state_q;
  logic [DEPTH_W-1:0] idx_q;
  logic [15:0]        rem_q;
  logic [31:0]        rdata_q;
  logic               rdv_q;
  logic               perr_q;
  logic [31:0]        mem_q [2**DEPTH_W];

  logic [DEPTH_W-1:0] idx_in;
  logic [DEPTH_W-1:0] wr_idx;
  logic [15:0]        bc_eff;
  logic               addr_err;
  logic               stall;
  logic               accept;
  logic               wr_en;

  assign idx_in   = address[DEPTH_W+1:2];
  assign bc_eff   = (burstcount == '0) ? 16'd1 : burstcount;
  assign addr_err = (address[1:0] != 2'b00) || ((address >> (DEPTH_W + 2)) != '0);

`ifdef AVMM_BURST_MEM_STALL_EN
  localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
  logic [SW-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall_q == STALL_LAST) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall = (stall_q == STALL_LAST);
`else
  assign stall = 1'b0;
`endif

  // waitrequest depends only on state and stall counter, never on read/write
  assign waitrequest = (state_q == RD_BURST) || stall;
  assign accept      = (read || write) && !waitrequest;
  assign wr_en       = !reset && write && !waitrequest && (state_q != RD_BURST);
  assign wr_idx      = (state_q == IDLE) ? idx_in : idx_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (write) begin
              if (bc_eff != 16'd1) begin
                state_q <= WR_BURST;
                idx_q   <= idx_in + 1'b1;
                rem_q   <= bc_eff - 16'd1;
              end
            end else begin
              state_q <= RD_BURST;
              idx_q   <= idx_in;
              rem_q   <= bc_eff;
            end
            if ((read && write) || (burstcount == '0) || addr_err) begin
              perr_q <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (write && !waitrequest) begin
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= IDLE;
            end
          end
          if (read) begin
            perr_q <= 1'b1;
          end
        end
        RD_BURST: begin
          // rem_q counts reads still to issue; the extra cycle at zero lets the last beat drain
          if (rem_q != '0) begin
            rdata_q <= mem_q[idx_q];
            rdv_q   <= 1'b1;
            idx_q   <= idx_q + 1'b1;
            rem_q   <= rem_q - 16'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign busy          = (state_q != IDLE);
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_avmm_burst_mem.sv
// Directed self-checking bench for avmm_burst_mem: vector table plus burst, wrap, reset and stall sequences.
module tb_avmm_burst_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [15:0] burstcount = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        busy;
  logic        proto_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] model [1024];
  logic [31:0] wdat  [16];
  logic [31:0] cap   [16];

  typedef struct {
    bit          rst;
    logic [31:0] waddr;
    logic [15:0] wbc;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [9];

  avmm_burst_mem #(.DEPTH_W(10), .STALL_PERIOD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .burstcount   (burstcount),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .waitrequest  (waitrequest),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdv", {31'd0, readdatavalid}, 32'd0);
    chk("rst_wait", {31'd0, waitrequest}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [15:0] bc, input int unsigned n);
    int unsigned beats = 0;
    int unsigned guard = 0;
    logic [9:0]  wi;
    wi = a[11:2];
    @(posedge clk); #1;
    write = 1'b1; address = a; burstcount = bc; writedata = wdat[0];
    while (beats < n && guard < 200) begin
      @(negedge clk);
      if (!waitrequest) begin
        model[wi] = wdat[beats];
        wi = wi + 10'd1;
        beats++;
      end
      @(posedge clk); #1;
      guard++;
      if (beats > 0) begin
        // later beats must ignore address/burstcount
        address = 32'hFFFF_FFFF;
        burstcount = '0;
      end
      if (beats < n) writedata = wdat[beats];
    end
    write = 1'b0; address = '0; burstcount = '0;
    chk("wr_beats", beats, n);
    @(negedge clk);
    chk("wr_done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_accept(output bit ok);
    int unsigned guard = 0;
    ok = 1'b0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      if (!waitrequest) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        guard++;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: waitrequest never low, required low within 50 cycles");
    end
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [15:0] bc, input int unsigned n);
    logic [9:0] wi;
    bit ok;
    wi = a[11:2];
    @(posedge clk); #1;
    read = 1'b1; address = a; burstcount = bc;
    wait_accept(ok);
    @(posedge clk); #1;
    read = 1'b0; address = '0; burstcount = '0;
    if (ok) begin
      @(negedge clk);
      chk("rd_first_gap", {31'd0, readdatavalid}, 32'd0);
      chk("rd_wait", {31'd0, waitrequest}, 32'd1);
      chk("rd_busy", {31'd0, busy}, 32'd1);
      for (int unsigned k = 0; k < n; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_valid", {31'd0, readdatavalid}, 32'd1);
        chk("rd_data", readdata, model[wi]);
        chk("rd_wait_beat", {31'd0, waitrequest}, 32'd1);
        cap[k] = readdata;
        wi = wi + 10'd1;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("rd_end_rdv", {31'd0, readdatavalid}, 32'd0);
      chk("rd_end_busy", {31'd0, busy}, 32'd0);
      chk("rd_hold", readdata, cap[n-1]);
`ifndef AVMM_BURST_MEM_STALL_EN
      chk("rd_end_wait", {31'd0, waitrequest}, 32'd0);
`endif
    end
  endtask

  initial begin
    bit ok;
    //         rst   waddr          wbc    wdata          raddr          exp_rd         perr
    vecs[0] = '{1'b0, 32'h0000_0010, 16'd1, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0020, 16'd1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0FFC, 16'd1, 32'hCAFE_F00D, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0010, 16'd1, 32'h0BAD_F00D, 32'h0000_0010, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0040, 16'd0, 32'hA5A5_A5A5, 32'h0000_0040, 32'hA5A5_A5A5, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_1002, 16'd1, 32'h1111_2222, 32'h0000_0000, 32'h1111_2222, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_2000, 16'd1, 32'h3333_4444, 32'h0000_0000, 32'h3333_4444, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0013, 16'd1, 32'h5555_6666, 32'h0000_0010, 32'h5555_6666, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0020, 16'd1, 32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 1'b0};

    do_reset();

    for (int unsigned i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      wdat[0] = vecs[i].wdata;
      wr_burst(vecs[i].waddr, vecs[i].wbc, 1);
      rd_burst(vecs[i].raddr, 16'd1, 1);
      chk($sformatf("vec%0d_rd", i), cap[0], vecs[i].exp_rd);
      chk($sformatf("vec%0d_perr", i), {31'd0, proto_err}, {31'd0, vecs[i].exp_perr});
    end

    // read && write together in IDLE: write serviced, read ignored
    do_reset();
    @(posedge clk); #1;
    read = 1'b1; write = 1'b1; address = 32'h80; burstcount = 16'd1; writedata = 32'h7777_8888;
    wait_accept(ok);
    model[10'h20] = 32'h7777_8888;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_perr", {31'd0, proto_err}, 32'd1);
    rd_burst(32'h80, 16'd1, 1);
    chk("rw_data", cap[0], 32'h7777_8888);

    // 8-beat burst write then burst read
    do_reset();
    for (int unsigned i = 0; i < 8; i++) wdat[i] = i;
    wr_burst(32'h100, 16'd8, 8);
    rd_burst(32'h100, 16'd8, 8);
    for (int unsigned i = 0; i < 8; i++) chk($sformatf("burst8_%0d", i), cap[i], i);
    chk("burst8_perr", {31'd0, proto_err}, 32'd0);

    // burst wrapping past the top word
    wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002; wdat[2] = 32'hCCCC_0003; wdat[3] = 32'hDDDD_0004;
    wr_burst(32'hFF8, 16'd4, 4);
    rd_burst(32'hFF8, 16'd4, 4);
    chk("wrap_3fe", cap[0], 32'hAAAA_0001);
    chk("wrap_3ff", cap[1], 32'hBBBB_0002);
    chk("wrap_000", cap[2], 32'hCCCC_0003);
    chk("wrap_001", cap[3], 32'hDDDD_0004);
    rd_burst(32'h0, 16'd1, 1);
    chk("wrap_single_000", cap[0], 32'hCCCC_0003);
    chk("wrap_perr", {31'd0, proto_err}, 32'd0);

    // reset during the third valid beat of a 16-beat read
    for (int unsigned i = 0; i < 16; i++) wdat[i] = 32'h5000_0000 + i;
    wr_burst(32'h200, 16'd16, 16);
    @(posedge clk); #1;
    read = 1'b1; address = 32'h200; burstcount = 16'd16;
    wait_accept(ok);
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_beat0", readdata, 32'h5000_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_beat2_rdv", {31'd0, readdatavalid}, 32'd1);
    chk("mid_beat2", readdata, 32'h5000_0002);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdv", {31'd0, readdatavalid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
`ifndef AVMM_BURST_MEM_STALL_EN
    chk("mid_rst_wait", {31'd0, waitrequest}, 32'd0);
`endif
    rd_burst(32'h200, 16'd4, 4);
    chk("mid_keep3", cap[3], 32'h5000_0003);

`ifdef AVMM_BURST_MEM_STALL_EN
    begin
      int unsigned beats = 0;
      int unsigned cyc = 0;
      int unsigned stalls = 0;
      int          last_stall = -1;
      int unsigned bad_gap = 0;
      do_reset();
      for (int unsigned i = 0; i < 12; i++) wdat[i] = 32'h9000_0000 + i;
      @(posedge clk); #1;
      write = 1'b1; address = 32'h300; burstcount = 16'd12; writedata = wdat[0];
      while (beats < 12 && cyc < 100) begin
        @(negedge clk);
        if (waitrequest) begin
          if (last_stall >= 0 && (int'(cyc) - last_stall) != 4) bad_gap++;
          last_stall = int'(cyc);
          stalls++;
        end else begin
          model[10'hC0 + beats[9:0]] = wdat[beats];
          beats++;
        end
        @(posedge clk); #1;
        cyc++;
        if (beats < 12) writedata = wdat[beats];
      end
      write = 1'b0;
      chk("stall_beats", beats, 32'd12);
      chk("stall_cycles", cyc, beats + stalls);
      chk("stall_gap", bad_gap, 32'd0);
      chk("stall_seen", {31'd0, (stalls >= 2)}, 32'd1);
      @(negedge clk);
      chk("stall_busy", {31'd0, busy}, 32'd0);
      rd_burst(32'h300, 16'd12, 12);
      for (int unsigned i = 0; i < 12; i++) chk($sformatf("stall_rd%0d", i), cap[i], 32'h9000_0000 + i);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
